brent_kung: RTL and testbench
=============================

Name: brent_kung

Overview:
- Parameterised binary adder built on a Brent-Kung parallel-prefix carry network.
- Computes {cout, s} = a + b + cin.
- Output stage is registered, so the block drops into a pipelined datapath with one cycle of latency.
- Default configuration is 32 bits. It is the adder core used wherever a log-depth, low-wiring carry structure is wanted.

Parameters:
- WIDTH, 32, operand and sum width. Must be a power of two, ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- s  output  WIDTH  registered sum bits
- cout  output  1  registered carry-out (bit WIDTH of the full sum)

Behaviour:
- Reset:
  - rst_n low clears s and cout to 0 immediately, with no clock needed.
  - Outputs hold 0 while rst_n is low.
  - Reset release is synchronous in effect: the first capture happens at the first rising clk edge with rst_n high.
- Latency:
  - a, b and cin are combinational into the prefix network and are not registered on input.
  - At each rising clk edge (rst_n high), s and cout capture the result of the a, b and cin values present before that edge.
  - Outputs are valid after exactly one edge and stay stable until the next edge.
- No handshake; every edge captures a new result. Holding the inputs constant holds the outputs constant.
- Pre-processing, per bit i: g_i = a_i & b_i; p_i = a_i ^ b_i.
- Carry-in handling: cin is folded in as the generate of a virtual bit -1, so the carry into bit 0 is c_0 = cin.
- Prefix operator: (G, P) ∘ (G', P') = (G | P&G', P&P').
- Up-sweep:
  - log2(WIDTH) levels.
  - Level k combines nodes at indices i where (i+1) is a multiple of 2^k, using span 2^(k-1).
- Down-sweep:
  - log2(WIDTH)-1 levels.
  - Fills the remaining group-generates G[i:0] for the indices not produced by the up-sweep.
- Carries: c_(i+1) = G[i:0] | (P[i:0] & cin).
- Outputs: s_i = p_i ^ c_i for i = 0..WIDTH-1; cout = c_WIDTH.
- Arithmetic:
  - Unsigned, modulo 2^(WIDTH+1) over {cout, s}.
  - The result must equal a + b + cin exactly for all 2^(2·WIDTH+1) input combinations.
  - No overflow flag is provided; signed overflow is derived externally if needed.
- Boundary cases:
  - All-ones + 0 + cin=1: carry propagates the full width, giving s = 0, cout = 1.
  - All-ones + all-ones + 1: s = all-ones, cout = 1.
- X/Z on any input may corrupt the outputs only for the cycle it is captured. No internal state beyond the output register.
- Reset asserted mid-operation: outputs go to 0 asynchronously, and the pending result is discarded.
- Implementation rules:
  - Generate loops are allowed.
  - A behavioural "+" operator for the sum is not permitted; the prefix tree must be explicit.

Test Plan:
- Reset: rst_n=0 with a=0x12345678, b=0x11111111 and clocks running → s=0x00000000, cout=0 throughout. Release rst_n, then 1 edge → s=0x23456789, cout=0.
- Full propagate: a=0xFFFFFFFF, b=0x00000000, cin=1 → after 1 edge s=0x00000000, cout=1. Same operands with cin=0 → s=0xFFFFFFFF, cout=0.
- Maximum values: a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 → s=0xFFFFFFFF, cout=1. With cin=0 → s=0xFFFFFFFE, cout=1.
- Mid-word carry: a=0x7FFFFFFF, b=0x00000001, cin=0 → s=0x80000000, cout=0. Also a=0x0000FFFF, b=0x00000001 → s=0x00010000.
- Cross-product regression: a 103-entry operand vector set (including 0, 1, all-ones, alternating 0xAAAAAAAA/0x55555555, single-bit walking patterns, random), all 103×103 pairs with cin=0, then repeated with cin=1. Check {cout,s} against the 33-bit golden a+b+cin one edge after apply, and log any mismatch as an error.
- Async reset mid-stream: assert rst_n low between clock edges while outputs hold 0xDEADBEEF → s and cout go to 0 before the next edge. Resume → correct sum one edge after release.

Source files
------------

// File: rtl/brent_kung.sv
// Brent-Kung parallel-prefix adder: {cout, s} = a + b + cin, with registered outputs.
// Up-sweep builds the power-of-two prefixes. Down-sweep fills in the remaining G[i:0].

module bk_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;
endmodule

module brent_kung #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  localparam int LOGW   = $clog2(WIDTH);
  localparam int STAGES = 2*LOGW - 1;

  // Row 0 holds the per-bit (g, p). Row st holds the (G, P) state after prefix level st.
  logic [STAGES:0][WIDTH-1:0] g_t, p_t;
  logic [WIDTH:0]             c;
  logic [WIDTH-1:0]           s_d, s_q;
  logic                       cout_d, cout_q;

  assign g_t[0] = a & b;
  assign p_t[0] = a ^ b;

  for (genvar st = 1; st <= STAGES; st++) begin : g_stage
    localparam int UP   = (st <= LOGW) ? 1 : 0;
    localparam int K    = (st <= LOGW) ? st : 2*LOGW - st;
    localparam int SPAN = 1 << (K-1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int ACT = UP ? (((i+1) % (2*SPAN)) == 0 ? 1 : 0)
                              : ((((i+1) % (2*SPAN)) == SPAN && i >= 2*SPAN) ? 1 : 0);
      if (ACT != 0) begin : g_node
        bk_cell u_cell (
          .g_hi_i (g_t[st-1][i]),
          .p_hi_i (p_t[st-1][i]),
          .g_lo_i (g_t[st-1][i-SPAN]),
          .p_lo_i (p_t[st-1][i-SPAN]),
          .g_o    (g_t[st][i]),
          .p_o    (p_t[st][i])
        );
      end else begin : g_pass
        assign g_t[st][i] = g_t[st-1][i];
        assign p_t[st][i] = p_t[st-1][i];
      end
    end
  end

  // cin acts as the generate of a virtual bit -1.
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign c[i+1] = g_t[STAGES][i] | (p_t[STAGES][i] & cin);
  end

  assign s_d    = p_t[0] ^ c[WIDTH-1:0];
  assign cout_d = c[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_brent_kung.sv
// Directed checks plus the operand cross-product for the 32-bit Brent-Kung adder.
module tb_brent_kung;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        cin;
  logic [31:0] s;
  logic        cout;

  int nchecks = 0;
  int nerrors = 0;
  logic [31:0] vec [103];

  brent_kung #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .s(s), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] exp);
    nchecks++;
    assert ({cout, s} === exp) else begin
      nerrors++;
      $error("FAIL %s: got %h expected %h", tag, {cout, s}, exp);
    end
  endtask

  task automatic step(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    a = av; b = bv; cin = cv;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; a = 32'h12345678; b = 32'h11111111; cin = 1'b0;
    #1 chk("reset_async", 33'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", 33'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_release", {1'b0, 32'h23456789});
    @(posedge clk); #1;
    chk("hold_const", {1'b0, 32'h23456789});

    step(32'hFFFFFFFF, 32'h00000000, 1'b1); chk("full_prop_c1", {1'b1, 32'h00000000});
    step(32'hFFFFFFFF, 32'h00000000, 1'b0); chk("full_prop_c0", {1'b0, 32'hFFFFFFFF});
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); chk("max_c1",       {1'b1, 32'hFFFFFFFF});
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); chk("max_c0",       {1'b1, 32'hFFFFFFFE});
    step(32'h7FFFFFFF, 32'h00000001, 1'b0); chk("mid_31",       {1'b0, 32'h80000000});
    step(32'h0000FFFF, 32'h00000001, 1'b0); chk("mid_16",       {1'b0, 32'h00010000});
    step(32'hAAAAAAAA, 32'h55555555, 1'b1); chk("alt_c1",       {1'b1, 32'h00000000});
    step(32'h00000000, 32'h00000000, 1'b1); chk("zero_c1",      {1'b0, 32'h00000001});
    step(32'h80000000, 32'h80000000, 1'b0); chk("msb_pair",     {1'b1, 32'h00000000});

    // Async reset between edges while the output holds 0xDEADBEEF.
    step(32'hDEADBEEF, 32'h00000000, 1'b0); chk("pre_async", {1'b0, 32'hDEADBEEF});
    #2 rst_n = 1'b0;
    #1 chk("async_mid", 33'h0);
    @(posedge clk); #1;
    chk("async_edge_low", 33'h0);
    rst_n = 1'b1; a = 32'h00000001; b = 32'h00000002; cin = 1'b1;
    @(posedge clk); #1;
    chk("async_resume", {1'b0, 32'h00000004});

    // Operand set: corners, walking ones/zeros, random fill.
    vec[0] = 32'h0; vec[1] = 32'h1; vec[2] = 32'hFFFFFFFF;
    vec[3] = 32'hAAAAAAAA; vec[4] = 32'h55555555;
    vec[5] = 32'h7FFFFFFF; vec[6] = 32'h80000000;
    vec[7] = 32'h0000FFFF; vec[8] = 32'hFFFF0000;
    for (int i = 0; i < 32; i++) begin
      vec[9+i]  = 32'h1 << i;
      vec[41+i] = ~(32'h1 << i);
    end
    for (int i = 73; i < 103; i++) vec[i] = $urandom;

    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 103; i++) begin
        for (int j = 0; j < 103; j++) begin
          logic [32:0] gold;
          gold = {1'b0, vec[i]} + {1'b0, vec[j]} + {32'h0, c[0]};
          step(vec[i], vec[j], c[0]);
          chk("xprod", gold);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
